// File: rtl/cache_pkg.sv
// Shared cache definitions: miss-handler FSM states and address-split constants.
// Used by cache_miss_handler and by the two-way set-associative data cache.
package cache_pkg;

  localparam int WORD_OFFSET_BITS = 2;
  localparam int SET_WIDTH        = 6;
  localparam int TAG_WIDTH        = 32 - SET_WIDTH - WORD_OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    FILL
  } miss_state_t;

endpackage

// File: rtl/cache_miss_handler_if.sv
// Pipeline, memory and fill signals of the cache miss handler.
// The handler uses the master modport. The pipeline, the memory and the cache use the slave modport.
interface cache_miss_handler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  req_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic                  hit_i;
  logic                  stall_o;
  logic                  mem_req_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  fill_en_o;
  logic [ADDR_WIDTH-1:0] fill_addr_o;
  logic [DATA_WIDTH-1:0] fill_data_o;

  modport master (
    input  req_i, addr_i, hit_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output stall_o, mem_req_o, mem_addr_o, fill_en_o, fill_addr_o, fill_data_o
  );

  modport slave (
    output req_i, addr_i, hit_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  stall_o, mem_req_o, mem_addr_o, fill_en_o, fill_addr_o, fill_data_o
  );

endinterface

// File: rtl/cache_stat_counter.sv
// Saturating 32-bit event counter with an increment enable.
// It is instantiated only in builds that define CACHE_MISS_STATS_EN.
module cache_stat_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/cache_miss_handler.sv
// Cache miss handler: stalls on a miss, fetches the word from memory and fills the cache.
// Defining CACHE_MISS_STATS_EN adds the hit and miss counter outputs.
module cache_miss_handler
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cache_miss_handler_if.master    bus
`ifdef CACHE_MISS_STATS_EN
  ,
  output logic [31:0]             hit_count_o,
  output logic [31:0]             miss_count_o
`endif
);

  miss_state_t           state, next_state;
  logic [ADDR_WIDTH-1:0] miss_addr;
  logic [DATA_WIDTH-1:0] fill_data;
  logic                  miss_seen;
  logic                  capture;

  assign miss_seen = bus.req_i && !bus.hit_i;

  // NOTE: sequential state uses <= so that every flop samples the values present before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      miss_addr <= '0;
      fill_data <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && miss_seen) begin
        miss_addr <= bus.addr_i;
      end
      if (capture) begin
        fill_data <= bus.mem_rdata_i;
      end
    end
  end

  // NOTE: every output gets a default first, so no branch can leave it unassigned and infer a latch.
  always_comb begin
    next_state     = state;
    capture        = 1'b0;
    bus.mem_req_o  = 1'b0;
    bus.mem_addr_o = '0;
    bus.fill_en_o  = 1'b0;
    unique case (state)
      IDLE: begin
        if (miss_seen) next_state = REQ;
      end
      REQ: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_addr_o = {miss_addr[ADDR_WIDTH-1:WORD_OFFSET_BITS], {WORD_OFFSET_BITS{1'b0}}};
        if (bus.mem_gnt_i && bus.mem_rvalid_i) begin
          capture    = 1'b1;
          next_state = FILL;
        end else if (bus.mem_gnt_i) begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid_i) begin
          capture    = 1'b1;
          next_state = FILL;
        end
      end
      FILL: begin
        bus.fill_en_o = 1'b1;
        next_state    = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The combinational miss term raises the stall in the same cycle that the miss is seen.
  assign bus.stall_o     = (state != IDLE) || miss_seen;
  assign bus.fill_addr_o = miss_addr;
  assign bus.fill_data_o = fill_data;

`ifdef CACHE_MISS_STATS_EN
  cache_stat_counter u_hit_count (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   ((state == IDLE) && bus.req_i && bus.hit_i),
    .count (hit_count_o)
  );

  cache_stat_counter u_miss_count (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   ((state == IDLE) && miss_seen),
    .count (miss_count_o)
  );
`endif

endmodule

// File: doc/cache_miss_handler.md
# cache_miss_handler

Miss handler that sits directly downstream of the two-way set-associative data cache. It detects a cache miss, stalls the pipeline, fetches the missing word from main memory over a request/grant/valid handshake, and writes the word back into the cache through a one-cycle fill strobe. The pipeline then replays the access, which hits.

## Interface
Parameters:
- DATA_WIDTH, 32, width of the data word and of the memory read data
- ADDR_WIDTH, 32, byte-address width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  synchronous reset, active-low
- req_i  in  1  pipeline has a valid cache access this cycle
- addr_i  in  ADDR_WIDTH  byte address of the access
- hit_i  in  1  hit flag from the cache for addr_i (combinational)
- stall_o  out  1  freeze the pipeline
- mem_req_o  out  1  read request to main memory
- mem_addr_o  out  ADDR_WIDTH  word-aligned request address (bits [1:0] = 0)
- mem_gnt_i  in  1  memory accepted the request
- mem_rvalid_i  in  1  mem_rdata_i valid
- mem_rdata_i  in  DATA_WIDTH  read data
- fill_en_o  out  1  cache fill strobe
- fill_addr_o  out  ADDR_WIDTH  fill address (the latched miss address)
- fill_data_o  out  DATA_WIDTH  fill data

## Operation
- FSM states: IDLE, REQ, WAIT, FILL.
- IDLE: if req_i && !hit_i, latch addr_i into miss_addr and go to REQ. Otherwise stay in IDLE. A request that hits causes no action.
- REQ: mem_req_o=1 and mem_addr_o={miss_addr[ADDR_WIDTH-1:2],2'b00}.
  - If mem_gnt_i && mem_rvalid_i: capture mem_rdata_i and go to FILL.
  - Else if mem_gnt_i: go to WAIT.
  - Else stay in REQ, with mem_req_o and mem_addr_o held stable.
- WAIT: mem_req_o=0. On mem_rvalid_i, capture mem_rdata_i into fill_data and go to FILL.
- FILL: fill_en_o=1 for exactly one cycle, with fill_addr_o=miss_addr and fill_data_o=the captured word. Next state is IDLE.
- stall_o = (state != IDLE) || (req_i && !hit_i). It is combinational, so the stall is asserted in the same cycle the miss is seen.
- mem_rvalid_i is ignored in IDLE and REQ unless mem_gnt_i is also high in REQ.
- mem_gnt_i is ignored outside REQ.
- addr_i, req_i and hit_i are ignored while not in IDLE; miss_addr is frozen.
- Reset values: state=IDLE, stall_o=0 (given req_i=0), mem_req_o=0, mem_addr_o=0, fill_en_o=0, fill_addr_o=0, fill_data_o=0, miss_addr=0.
- Reset during any state returns to IDLE on that edge and drops the outstanding request. A later mem_rvalid_i is then ignored.

## Timing
- Miss seen in cycle N: stall_o=1 in N; mem_req_o=1 from N+1.
- Grant in cycle G and rvalid in cycle R>G: FILL in cycle R+1; stall_o falls in R+2, when the replay hits.
- Grant and rvalid both in cycle G: FILL in cycle G+1.
- Minimum miss penalty is 3 cycles of stall: N, REQ, FILL.
- fill_en_o is held for the whole FILL cycle, so the cache's negedge write captures it.
- Back-to-back misses: the miss in the cycle after FILL starts a new sequence. There are no idle gaps imposed.

## Configuration
- CACHE_MISS_STATS_EN defined:
  - Adds output hit_count_o [31:0], incremented in IDLE on req_i && hit_i.
  - Adds output miss_count_o [31:0], incremented on each IDLE→REQ transition.
  - Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
  - A replayed access counts as a hit.
- Not defined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package cache_pkg holds:
  - the miss_state_t enum (IDLE, REQ, WAIT, FILL)
  - the WORD_OFFSET_BITS=2 constant
  - the shared SET_WIDTH and TAG_WIDTH constants, also used by the cache
- Sub-module cache_stat_counter: a saturating 32-bit counter with an increment enable. It is instantiated twice, only under CACHE_MISS_STATS_EN.

## Test plan
- Reset with rst_n=0 for 2 cycles, req_i=1, hit_i=0 → all outputs 0; state IDLE after release; stall_o rises only through the combinational term.
- Miss at addr_i=0x0000_1236; gnt 2 cycles later; rvalid with 0xDEAD_BEEF 3 cycles after gnt → mem_addr_o=0x0000_1234; fill_en_o=1 for one cycle with fill_addr_o=0x0000_1236 and fill_data_o=0xDEAD_BEEF; stall_o falls the cycle after FILL.
- gnt and rvalid in the first REQ cycle, data 0x1234_5678 → FILL the next cycle; total stall of 3 cycles.
- Hit access (req_i=1, hit_i=1) in IDLE → stall_o=0 and mem_req_o=0; with CACHE_MISS_STATS_EN, hit_count_o increments by 1.
- rst_n=0 asserted in WAIT, then rvalid pulses after release → no FILL and no fill_en_o; state remains IDLE.
- Two consecutive misses, to 0x100 then 0x200 → two distinct fills with matching addresses; with CACHE_MISS_STATS_EN, miss_count_o=2 and the replays give hit_count_o=2.
